mod4_batch_arb: RTL

MOD4_BATCH_ARB -- requirements
Module: mod4_batch_arb

---
 rtl/mod4_batch_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mod4_batch_arb.sv
// Two-requester round-robin batch arbiter with a mod-4 ones-count check.
// A granted requester streams (x, y) sample pairs; the arbiter accumulates
// the ones count modulo 4 and, after batch_len accepted samples, pulses done
// with div4 = (count mod 4 == 0) and the requester index on res_id.
// Optional feature: define MOD4_ARB_ABORT_EN to cancel a running batch when
// the granted requester drops its req bit (abort pulse, no done).
module mod4_batch_arb #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] batch_len,
  input  logic             vld0,
  input  logic             vld1,
  input  logic             x0,
  input  logic             y0,
  input  logic             x1,
  input  logic             y1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             div4,
  output logic             res_id,
  output logic             abort
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  // Last-served requester; it is also the granted index while a batch runs.
  // Reset value 1 gives requester 0 priority on the first contended grant.
  logic             ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       acc_q, acc_d;
  logic             div4_q, div4_d;
  logic             res_id_q, res_id_d;
`ifdef MOD4_ARB_ABORT_EN
  logic             abort_q, abort_d;
`endif

  logic             win;
  logic             s_vld;
  logic [1:0]       s_sum;
  logic [LEN_W-1:0] cnt_inc;

  // Round-robin winner among the current requests.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr_q;
      default: win = 1'b0;
    endcase
  end

  // Select the granted requester's sample; the other requester is ignored.
  always_comb begin
    if (ptr_q) begin
      s_vld = vld1;
      s_sum = {1'b0, x1} + {1'b0, y1};
    end else begin
      s_vld = vld0;
      s_sum = {1'b0, x0} + {1'b0, y0};
    end
    cnt_inc = cnt_q + LEN_W'(1);
  end

  // Next-state logic for the batch FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    div4_d   = div4_q;
    res_id_d = res_id_q;
`ifdef MOD4_ARB_ABORT_EN
    abort_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        div4_d   = 1'b0;
        res_id_d = 1'b0;
        if (req != 2'b00) begin
          state_d = StRun;
          gnt_d   = win ? 2'b10 : 2'b01;
          ptr_d   = win;
          len_d   = batch_len;
          cnt_d   = '0;
          acc_d   = 2'b00;
        end
      end
      StRun: begin
`ifdef MOD4_ARB_ABORT_EN
        // A request drop wins over everything, including the final sample.
        if (!req[ptr_q]) begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          abort_d = 1'b1;
        end else
`endif
        if (len_q == '0) begin
          // Empty batch: one RUN cycle, no sample taken, count is trivially 0.
          state_d  = StDone;
          gnt_d    = 2'b00;
          div4_d   = 1'b1;
          res_id_d = ptr_q;
        end else if (s_vld) begin
          acc_d = acc_q + s_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d  = StDone;
            gnt_d    = 2'b00;
            div4_d   = (acc_d == 2'b00);
            res_id_d = ptr_q;
          end
        end
      end
      StDone: begin
        // No grant is issued here; arbitration resumes from IDLE.
        state_d  = StIdle;
        div4_d   = 1'b0;
        res_id_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= 2'b00;
      ptr_q    <= 1'b1;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= 2'b00;
      div4_q   <= 1'b0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      div4_q   <= div4_d;
      res_id_q <= res_id_d;
    end
  end

`ifdef MOD4_ARB_ABORT_EN
  // One-cycle abort pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end

  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign div4   = div4_q;
  assign res_id = res_id_q;

endmodule
